// File: rtl/ej32_trace_buf.sv
// ej32_trace_buf: per-cycle execution trace recorder for the eJ32 core.
//
// This block captures {code, ph, rp, sp, p, t} records into a DEPTH-entry
// circular RAM. It runs in one of three capture modes, selected when
// capture is armed:
//   WRAP (free-run), FULL (stop on full), TRIG (opcode trigger + post count).
// A random-access read port returns records oldest-first, one cycle after
// the request.
//
// Optional feature macro: TRACE_FILTER_EN
//   When defined, only cycles with cap_ph == 0 are recorded or can fire the
//   trigger, which gives one record per instruction boundary.
//
// Ports:
//   clk, rst        core clock; synchronous active-high reset
//   arm             restart pulse: clears counters and enters the mode
//   mode            0=WRAP, 1=FULL, 2=TRIG, 3=WRAP
//   trig_code       opcode that fires the trigger in TRIG mode
//   post_cnt        number of records kept after the trigger record
//   cap_*           capture qualifier and the record fields
//   rd_en, rd_idx   read request; index is relative to the oldest record
//   rd_data, rd_vld read result, one cycle later
//   count           records held (saturates at DEPTH)
//   trig_pos        oldest-relative index of the trigger record
//   busy, done      capture in progress / capture finished
module ej32_trace_buf #(
  parameter  int unsigned DEPTH = 64,
  parameter  int unsigned AW    = 16,
  parameter  int unsigned TW    = 32,
  localparam int unsigned DW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic [1:0]           mode,
  input  logic [7:0]           trig_code,
  input  logic [DW-1:0]        post_cnt,
  input  logic                 cap_vld,
  input  logic [7:0]           cap_code,
  input  logic [2:0]           cap_ph,
  input  logic [4:0]           cap_rp,
  input  logic [4:0]           cap_sp,
  input  logic [AW-1:0]        cap_p,
  input  logic [TW-1:0]        cap_t,
  input  logic                 rd_en,
  input  logic [DW-1:0]        rd_idx,
  output logic [21+AW+TW-1:0]  rd_data,
  output logic                 rd_vld,
  output logic [DW:0]          count,
  output logic [DW-1:0]        trig_pos,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned RW = 21 + AW + TW;
  localparam logic [DW:0] CNT_FULL = (DW+1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_CAP, S_PRE, S_POST, S_DONE} state_t;

  state_t        state, state_n;
  logic [DW-1:0] wptr, post_left, post_n, trig_slot, tslot_n;
  logic          trig_seen, tseen_n, full_mode, full_n;
  logic          we, clr, sample, hit;
  logic [DW-1:0] wbase, oldest, rd_addr;
  logic [DW:0]   cbase;
  logic [RW-1:0] mem [DEPTH];
  logic [RW-1:0] record;

`ifdef TRACE_FILTER_EN
  assign sample = cap_vld && (cap_ph == 3'd0);
  assign hit    = (cap_code == trig_code) && (cap_ph == 3'd0);
`else
  assign sample = cap_vld;
  assign hit    = (cap_code == trig_code);
`endif

  assign record = {cap_code, cap_ph, cap_rp, cap_sp, cap_p, cap_t};

  // Once the buffer has wrapped, the oldest record sits at the write pointer.
  assign oldest   = count[DW] ? wptr : '0;
  assign rd_addr  = oldest + rd_idx;
  // Tracks the oldest slot while capture continues, so it stays correct after
  // the post-trigger records push older ones out.
  assign trig_pos = trig_seen ? (trig_slot - oldest) : '0;

  // arm acts as a same-edge restart: the counters are taken from zero, and
  // the sample presented with arm becomes record 0.
  assign wbase = clr ? '0 : wptr;
  assign cbase = clr ? '0 : count;

  always_comb begin
    state_n = state;
    we      = 1'b0;
    clr     = 1'b0;
    post_n  = post_left;
    tslot_n = trig_slot;
    tseen_n = trig_seen;
    full_n  = full_mode;
    if (arm) begin
      clr     = 1'b1;
      we      = sample;
      full_n  = (mode == 2'd1);
      tseen_n = 1'b0;
      if (mode == 2'd2) begin
        state_n = S_PRE;
        if (sample && hit) begin
          state_n = S_POST;
          tslot_n = '0;
          tseen_n = 1'b1;
          post_n  = post_cnt;
        end
      end else begin
        state_n = S_CAP;
      end
    end else begin
      case (state)
        S_CAP: begin
          we = sample;
          if (full_mode && sample && (count == CNT_FULL - (DW+1)'(1)))
            state_n = S_DONE;
        end
        S_PRE: begin
          we = sample;
          if (sample && hit) begin
            state_n = S_POST;
            tslot_n = wptr;
            tseen_n = 1'b1;
            post_n  = post_cnt;
          end
        end
        S_POST: begin
          if (post_left == '0) begin
            state_n = S_DONE;
          end else if (sample) begin
            we     = 1'b1;
            post_n = post_left - DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      wptr      <= '0;
      count     <= '0;
      post_left <= '0;
      trig_slot <= '0;
      trig_seen <= 1'b0;
      full_mode <= 1'b0;
    end else begin
      state     <= state_n;
      busy      <= (state_n == S_CAP) || (state_n == S_PRE) || (state_n == S_POST);
      done      <= (state_n == S_DONE);
      wptr      <= we ? wbase + DW'(1) : wbase;
      count     <= (we && (cbase != CNT_FULL)) ? cbase + (DW+1)'(1) : cbase;
      post_left <= post_n;
      trig_slot <= tslot_n;
      trig_seen <= tseen_n;
      full_mode <= full_n;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wbase] <= record;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_vld <= rd_en;
      if (rd_en) rd_data <= ({1'b0, rd_idx} < count) ? mem[rd_addr] : '0;
    end
  end

endmodule
